cabac_se_parse_mvd: RTL

Decoder-side MVD syntax-element parser. It sequences the HEVC mvd_coding and mvp_lx_flag syntax elements in bitstream order and tells the bin decoder which context to use for each one. It accepts one decoded value per handshake and rebuilds the signed MVD pair plus the MVP index. It sits between the CABAC bin decoder and the inter-prediction MV reconstruction stage, and is the inverse of the encoder's MVD syntax-element preparation.

---
 rtl/cabac_se_parse_mvd_pkg.sv | 67 ++++++
 rtl/cabac_mvd_rebuild.sv | 45 ++++
 rtl/cabac_se_parse_mvd.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/cabac_se_parse_mvd_pkg.sv
// Shared constants, state encoding and sequencing helpers for the MVD syntax-element parser.
// Optional overflow checking is enabled by defining CABAC_MVD_ERR_CHK_EN.
package cabac_se_parse_mvd_pkg;

    localparam int MVD_WIDTH = 11;

    localparam logic [8:0] CTX_MVD_G0  = 9'h016;
    localparam logic [8:0] CTX_MVD_G1  = 9'h017;
    localparam logic [8:0] CTX_MVD_M2  = 9'h0be;
    localparam logic [8:0] CTX_MVD_SGN = 9'h0bb;
    localparam logic [8:0] CTX_MVP_IDX = 9'h0b0;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_G0X  = 4'd1,
        ST_G0Y  = 4'd2,
        ST_G1X  = 4'd3,
        ST_G1Y  = 4'd4,
        ST_M2X  = 4'd5,
        ST_SX   = 4'd6,
        ST_M2Y  = 4'd7,
        ST_SY   = 4'd8,
        ST_MVP  = 4'd9,
        ST_DONE = 4'd10
    } state_t;

    // Position i in the optional-step order G1X, G1Y, M2X, SX, M2Y, SY, MVP.
    function automatic state_t mvd_step(input int i);
        state_t s;
        case (i)
            0:       s = ST_G1X;
            1:       s = ST_G1Y;
            2:       s = ST_M2X;
            3:       s = ST_SX;
            4:       s = ST_M2Y;
            5:       s = ST_SY;
            default: s = ST_MVP;
        endcase
        return s;
    endfunction

    // First step at or after position 'from' whose condition holds; MVP always qualifies.
    function automatic state_t mvd_walk(input logic [2:0] from, input logic [5:0] ok);
        state_t r;
        r = ST_MVP;
        for (int i = 5; i >= 0; i--) begin
            if (i >= int'(from) && ok[i]) begin
                r = mvd_step(i);
            end
        end
        return r;
    endfunction

    function automatic logic [8:0] ctx_of(input state_t s);
        logic [8:0] c;
        case (s)
            ST_G0X, ST_G0Y: c = CTX_MVD_G0;
            ST_G1X, ST_G1Y: c = CTX_MVD_G1;
            ST_M2X, ST_M2Y: c = CTX_MVD_M2;
            ST_SX,  ST_SY:  c = CTX_MVD_SGN;
            ST_MVP:         c = CTX_MVP_IDX;
            default:        c = 9'h000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cabac_mvd_rebuild.sv
// Combinational rebuild of one signed MVD component from its parsed flags and remainder.
// With CABAC_MVD_ERR_CHK_EN the component saturates and flags overflow; otherwise it wraps.
module cabac_mvd_rebuild
    import cabac_se_parse_mvd_pkg::*;
(
    input  logic                 g0,
    input  logic                 g1,
    input  logic [9:0]           minus2,
    input  logic                 sign,
    output logic [MVD_WIDTH-1:0] val
`ifdef CABAC_MVD_ERR_CHK_EN
    ,
    output logic                 ovf
`endif
);

    logic        [MVD_WIDTH-1:0] mag;
    logic signed [MVD_WIDTH-1:0] sval;

`ifdef CABAC_MVD_ERR_CHK_EN
    function automatic logic [MVD_WIDTH-1:0] sat_mvd(input logic neg);
        return neg ? {1'b1, {(MVD_WIDTH-1){1'b0}}} : {1'b0, {(MVD_WIDTH-1){1'b1}}};
    endfunction
`endif

    always_comb begin
        if (!g0) begin
            mag = '0;
        end else if (!g1) begin
            mag = MVD_WIDTH'(1);
        end else begin
            mag = MVD_WIDTH'(minus2) + MVD_WIDTH'(2);
        end
        sval = sign ? -$signed(mag) : $signed(mag);
    end

`ifdef CABAC_MVD_ERR_CHK_EN
    // Negative range reaches one further than positive (-1024 vs +1023).
    assign ovf = sign ? (mag > MVD_WIDTH'(1024)) : (mag > MVD_WIDTH'(1023));
    assign val = ovf ? sat_mvd(sign) : sval;
`else
    assign val = sval;
`endif

endmodule

// File: rtl/cabac_se_parse_mvd.sv
// Sequences mvd_coding / mvp_lx_flag requests to the bin decoder and rebuilds {mvd_x, mvd_y} and mvp_idx.
// Define CABAC_MVD_ERR_CHK_EN to enable magnitude overflow detection (err_o) and saturation.
module cabac_se_parse_mvd
    import cabac_se_parse_mvd_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   se_valid_i,
    input  logic [9:0]             se_val_i,
    output logic                   se_ready_o,
    output logic [8:0]             se_ctx_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [2*MVD_WIDTH-1:0] mv_o,
    output logic [2:0]             mvp_idx_o,
    output logic                   err_o
);

    state_t state, state_nxt;

    logic       beat;
    logic       bin;
    logic       g0x, g0y, g1x, g1y, sx, sy;
    logic [9:0] m2x, m2y;
    logic       g0x_n, g0y_n, g1x_n, g1y_n;
    logic [5:0] ok;

    logic [MVD_WIDTH-1:0] vx, vy;

    assign se_ready_o = (state != ST_IDLE) && (state != ST_DONE);
    assign se_ctx_o   = ctx_of(state);
    assign busy_o     = (state != ST_IDLE);
    assign done_o     = (state == ST_DONE);
    assign beat       = se_valid_i & se_ready_o;
    assign bin        = se_val_i[0];

    // Step conditions must see the flag decoded on this very beat.
    always_comb begin
        g0x_n = (state == ST_G0X) ? bin : g0x;
        g0y_n = (state == ST_G0Y) ? bin : g0y;
        g1x_n = (state == ST_G1X) ? bin : g1x;
        g1y_n = (state == ST_G1Y) ? bin : g1y;
        ok    = {g0y_n, g1y_n, g0x_n, g1x_n, g0y_n, g0x_n};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_i) state_nxt = ST_G0X;
            ST_G0X:  if (beat) state_nxt = ST_G0Y;
            ST_G0Y:  if (beat) state_nxt = mvd_walk(3'd0, ok);
            ST_G1X:  if (beat) state_nxt = mvd_walk(3'd1, ok);
            ST_G1Y:  if (beat) state_nxt = mvd_walk(3'd2, ok);
            ST_M2X:  if (beat) state_nxt = mvd_walk(3'd3, ok);
            ST_SX:   if (beat) state_nxt = mvd_walk(3'd4, ok);
            ST_M2Y:  if (beat) state_nxt = mvd_walk(3'd5, ok);
            ST_SY:   if (beat) state_nxt = mvd_walk(3'd6, ok);
            ST_MVP:  if (beat) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Parsed syntax elements; cleared at the start of every PU so skipped elements read as zero.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start_i) begin
            g0x <= 1'b0;
            g0y <= 1'b0;
            g1x <= 1'b0;
            g1y <= 1'b0;
            sx  <= 1'b0;
            sy  <= 1'b0;
            m2x <= '0;
            m2y <= '0;
        end else if (beat) begin
            case (state)
                ST_G0X:  g0x <= bin;
                ST_G0Y:  g0y <= bin;
                ST_G1X:  g1x <= bin;
                ST_G1Y:  g1y <= bin;
                ST_M2X:  m2x <= se_val_i;
                ST_SX:   sx  <= bin;
                ST_M2Y:  m2y <= se_val_i;
                ST_SY:   sy  <= bin;
                default: ;
            endcase
        end
    end

`ifdef CABAC_MVD_ERR_CHK_EN
    logic ovf_x, ovf_y;
`endif

    cabac_mvd_rebuild u_rebuild_x (
        .g0     (g0x),
        .g1     (g1x),
        .minus2 (m2x),
        .sign   (sx),
        .val    (vx)
`ifdef CABAC_MVD_ERR_CHK_EN
        ,
        .ovf    (ovf_x)
`endif
    );

    cabac_mvd_rebuild u_rebuild_y (
        .g0     (g0y),
        .g1     (g1y),
        .minus2 (m2y),
        .sign   (sy),
        .val    (vy)
`ifdef CABAC_MVD_ERR_CHK_EN
        ,
        .ovf    (ovf_y)
`endif
    );

    // Results land on the MVP beat so they are visible in the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mv_o      <= '0;
            mvp_idx_o <= '0;
        end else if (state == ST_MVP && beat) begin
            mv_o      <= {vx, vy};
            mvp_idx_o <= {2'b00, bin};
        end
    end

`ifdef CABAC_MVD_ERR_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_o <= 1'b0;
        end else if (state == ST_IDLE && start_i) begin
            err_o <= 1'b0;
        end else if (state == ST_MVP && beat) begin
            err_o <= err_o | ovf_x | ovf_y;
        end
    end
`else
    assign err_o = 1'b0;
`endif

endmodule
